affine_row_interp: RTL and testbench
====================================

Name: affine_row_interp

Overview:
- Consumer side of the 1/16-precision affine MCM tap filters: streams one row of 8-bit reference samples and keeps a 6-sample window.
- For the row's fractional phase, forms the six tap products and sums them through a pipelined adder. Emits one interpolated sample per input beyond the first five.
- Sits between the reference-sample fetch buffer and the prediction writeback, using valid/ready on both sides.

Parameters:
- IN_SIZE, 8, signed input sample width.
- OUT_SIZE, 16, signed output width; must be >= IN_SIZE+8.
- ROW_LEN, 16, output samples per row; row consumes ROW_LEN+5 inputs.
- CNT_W, 6, counter width; must satisfy 2^CNT_W > ROW_LEN+5.

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- start  in  1  begin row; sampled only in IDLE
- frac  in  4  fractional phase 0..15, latched on accepted start
- in_valid  in  1  input sample valid
- in_ready  out  1  block accepts sample this cycle
- in_data  in  IN_SIZE  signed reference sample
- out_valid  out  1  output sample valid
- out_ready  in  1  downstream accepts output
- out_data  out  OUT_SIZE  signed interpolated sample
- out_last  out  1  marks final sample of row
- busy  out  1  high from accepted start until last output handshake

Behaviour:
- Interface: one clock (clk); reset synchronous, active-low (rst_n).
- Reset state:
  - FSM=IDLE; in_ready=0, out_valid=0, out_last=0, busy=0, out_data=0.
  - Window, counters, pipeline valids and frac register cleared.
  - Reset mid-row abandons the row; no partial output.
- FSM:
  - IDLE: start=1 latches frac, clears counters, goes to FILL.
  - FILL: accepts 5 samples into the window, no output; after the 5th goes to RUN.
  - RUN: each accepted sample shifts the window (oldest out, newest at tap 5) and launches one computation; after the (ROW_LEN+5)th sample goes to DRAIN.
  - DRAIN: in_ready=0; waits until the out_last handshake, then returns to IDLE.
- start outside IDLE is ignored. start and in_valid in the same IDLE cycle: start is taken, the sample is not (in_ready=0 in IDLE).
- Handshake:
  - Transfers occur on valid&ready.
  - in_ready = (FILL or RUN) and not stalled; stalled = output register full and out_ready=0.
  - out_valid, once high, holds out_data and out_last stable until out_ready.
- Arithmetic:
  - p_k = in window[k] * COEF[k][frac], k=0..5, signed, exact.
  - sum = sum of p_k, sign-extended to OUT_SIZE, no overflow by construction.
  - Coefficient rows sum to 64; frac=0 is {0,0,64,0,0,0}, i.e. tap 2 passthrough.
- Latency and throughput:
  - Pipeline stage 1 registers the three pair sums; stage 2 registers the final sum into the output register.
  - First output is valid 2 cycles after the 6th input handshake. Full throughput (1 sample/cycle) when out_ready is held at 1.
  - When stalled, all stages freeze; no sample is lost or duplicated.
- out_last is high with the ROW_LEN-th output. busy drops in the cycle after that handshake. A new start is accepted in the following cycle.

Optional Feature:
- Macro: AFFINE_ROUND_EN.
  - Defined: out_data = (sum + 32) >>> 6, saturated to the signed IN_SIZE range, then sign-extended to OUT_SIZE. Rounding occupies stage 2, so latency is unchanged.
  - Undefined: out_data is the raw 14-bit-scaled sum (intermediate precision for a following vertical pass).

Decomposition:
- Package affine_interp_pkg holds:
  - COEF_AFFINE[16][6] signed 8-bit coefficient table;
  - NUM_TAPS=6, FRAC_W=4, PRE_TAPS=5;
  - the state enum {IDLE, FILL, RUN, DRAIN}.
- One sub-module, affine_tap_sum: combinational six-product computation plus pair-sum split for the pipeline.
- FSM, counters, window and handshake logic stay in the top.

Test Plan:
- Reset: rst_n=0 for 3 cycles mid-RUN -> all outputs 0, FSM IDLE, and the next row behaves normally.
- DC row, macro undefined: frac=7, 21 inputs of value 10, out_ready=1 -> 16 outputs of 640; out_last on the 16th; first out_valid 2 cycles after the 6th input.
- Passthrough, macro defined: frac=0, inputs 0..20 -> outputs 2..17 in order.
- Negative and saturation, macro defined: frac=5, all inputs -128 -> all outputs -128 with no wrap; +127 inputs -> all outputs 127.
- Backpressure: out_ready toggled 1,0,0,1 repeating with in_valid random -> output sequence identical to the unstalled run; out_data stable while out_valid&!out_ready.
- Protocol edges: start held high during RUN -> ignored. Back-to-back rows, with start one cycle after busy falls -> second row correct, frac changed from 3 to 12.

Source files
------------

// File: rtl/affine_interp_pkg.sv
// Shared definitions for the affine 6-tap row interpolator.
// Contents: tap/phase geometry constants, the 1/16-phase coefficient table
// (each row sums to 64, phase 0 is a pure tap-2 passthrough) and the row FSM
// state type.
package affine_interp_pkg;

  localparam int unsigned NUM_TAPS  = 6;
  localparam int unsigned NUM_PAIRS = 3;
  localparam int unsigned FRAC_W    = 4;
  localparam int unsigned PRE_TAPS  = 5;
  localparam int unsigned COEF_W    = 8;

  typedef enum logic [1:0] {IDLE, FILL, RUN, DRAIN} state_e;

  // Rows 9..15 mirror rows 7..1.
  localparam logic signed [COEF_W-1:0] COEF_AFFINE [16][NUM_TAPS] = '{
    '{ 8'sd0,   8'sd0, 8'sd64,  8'sd0,   8'sd0, 8'sd0},
    '{ 8'sd1,  -8'sd3, 8'sd63,  8'sd4,  -8'sd2, 8'sd1},
    '{ 8'sd1,  -8'sd5, 8'sd62,  8'sd8,  -8'sd3, 8'sd1},
    '{ 8'sd2,  -8'sd8, 8'sd60, 8'sd13,  -8'sd4, 8'sd1},
    '{ 8'sd3, -8'sd10, 8'sd58, 8'sd17,  -8'sd5, 8'sd1},
    '{ 8'sd3, -8'sd11, 8'sd52, 8'sd26,  -8'sd8, 8'sd2},
    '{ 8'sd2,  -8'sd9, 8'sd47, 8'sd31, -8'sd10, 8'sd3},
    '{ 8'sd3, -8'sd11, 8'sd45, 8'sd34, -8'sd10, 8'sd3},
    '{ 8'sd3, -8'sd11, 8'sd40, 8'sd40, -8'sd11, 8'sd3},
    '{ 8'sd3, -8'sd10, 8'sd34, 8'sd45, -8'sd11, 8'sd3},
    '{ 8'sd3, -8'sd10, 8'sd31, 8'sd47,  -8'sd9, 8'sd2},
    '{ 8'sd2,  -8'sd8, 8'sd26, 8'sd52, -8'sd11, 8'sd3},
    '{ 8'sd1,  -8'sd5, 8'sd17, 8'sd58, -8'sd10, 8'sd3},
    '{ 8'sd1,  -8'sd4, 8'sd13, 8'sd60,  -8'sd8, 8'sd2},
    '{ 8'sd1,  -8'sd3,  8'sd8, 8'sd62,  -8'sd5, 8'sd1},
    '{ 8'sd1,  -8'sd2,  8'sd4, 8'sd63,  -8'sd3, 8'sd1}
  };

endpackage

// File: rtl/affine_tap_sum.sv
// Combinational six-tap product stage with pair-sum split.
// Ports:
//   frac     - phase selecting the coefficient row
//   taps     - six signed window samples, tap 0 oldest
//   pair_sum - (p0+p1), (p2+p3), (p4+p5), exact
module affine_tap_sum
  import affine_interp_pkg::*;
#(
  parameter int unsigned IN_SIZE = 8,
  parameter int unsigned PAIR_W  = IN_SIZE + 9
) (
  input  logic [FRAC_W-1:0]         frac,
  input  logic signed [IN_SIZE-1:0] taps     [NUM_TAPS],
  output logic signed [PAIR_W-1:0]  pair_sum [NUM_PAIRS]
);

  localparam int unsigned PROD_W = IN_SIZE + COEF_W;

  logic signed [PROD_W-1:0] prod [NUM_TAPS];

  always_comb begin
    for (int k = 0; k < NUM_TAPS; k++) begin
      prod[k] = PROD_W'(taps[k]) * PROD_W'(COEF_AFFINE[frac][k]);
    end
    for (int j = 0; j < NUM_PAIRS; j++) begin
      pair_sum[j] = PAIR_W'(prod[2*j]) + PAIR_W'(prod[2*j+1]);
    end
  end

endmodule

// File: rtl/affine_row_interp.sv
// Streaming affine 6-tap horizontal interpolator for one row of samples.
// Ports:
//   clk, rst_n            - clock, synchronous active-low reset
//   start, frac           - begin a row (IDLE only), phase latched on start
//   in_valid/ready/data   - reference sample stream, ROW_LEN+5 per row
//   out_valid/ready/data  - interpolated samples, ROW_LEN per row
//   out_last              - final sample of the row
//   busy                  - row in progress
// Build option AFFINE_ROUND_EN: round (sum+32)>>>6 and saturate to the input
// range; otherwise out_data carries the raw 64x-scaled sum.
module affine_row_interp
  import affine_interp_pkg::*;
#(
  parameter int unsigned IN_SIZE  = 8,
  parameter int unsigned OUT_SIZE = 16,
  parameter int unsigned ROW_LEN  = 16,
  parameter int unsigned CNT_W    = 6
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [FRAC_W-1:0]          frac,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic signed [IN_SIZE-1:0]  in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [OUT_SIZE-1:0] out_data,
  output logic                       out_last,
  output logic                       busy
);

  localparam int unsigned PAIR_W = IN_SIZE + 9;

  state_e                     state_q, state_d;
  logic [FRAC_W-1:0]          frac_q;
  logic [CNT_W-1:0]           cnt_q;
  logic signed [IN_SIZE-1:0]  win_q [NUM_TAPS];
  logic signed [IN_SIZE-1:0]  taps  [NUM_TAPS];
  logic signed [PAIR_W-1:0]   pair_d [NUM_PAIRS];
  logic signed [PAIR_W-1:0]   pair_q [NUM_PAIRS];
  logic                       s1_valid_q, s1_last_q;
  logic                       out_valid_q, out_last_q;
  logic signed [OUT_SIZE-1:0] out_data_q, sum_full, out_next;
  logic                       stalled, in_fire, launch, last_launch, out_fire;

  assign stalled     = out_valid_q & ~out_ready;
  assign in_ready    = ((state_q == FILL) || (state_q == RUN)) && !stalled;
  assign in_fire     = in_valid & in_ready;
  assign launch      = in_fire && (state_q == RUN);
  assign last_launch = launch && (cnt_q == CNT_W'(ROW_LEN + PRE_TAPS - 1));
  assign out_fire    = out_valid_q & out_ready;

  // Window as it will be after accepting in_data; the computation launches
  // from this view so the new sample sits at tap 5 without an extra cycle.
  always_comb begin
    for (int k = 0; k < NUM_TAPS - 1; k++) begin
      taps[k] = win_q[k+1];
    end
    taps[NUM_TAPS-1] = in_data;
  end

  affine_tap_sum #(
    .IN_SIZE(IN_SIZE),
    .PAIR_W (PAIR_W)
  ) u_tap_sum (
    .frac    (frac_q),
    .taps    (taps),
    .pair_sum(pair_d)
  );

  always_comb begin
    sum_full = OUT_SIZE'(pair_q[0]) + OUT_SIZE'(pair_q[1]) + OUT_SIZE'(pair_q[2]);
  end

`ifdef AFFINE_ROUND_EN
  localparam logic signed [OUT_SIZE-1:0] SAT_MAX = OUT_SIZE'((2 ** (IN_SIZE - 1)) - 1);
  localparam logic signed [OUT_SIZE-1:0] SAT_MIN = -SAT_MAX - OUT_SIZE'(1);

  logic signed [OUT_SIZE-1:0] rnd;

  always_comb begin
    rnd = (sum_full + OUT_SIZE'(32)) >>> 6;
    if (rnd > SAT_MAX) begin
      out_next = SAT_MAX;
    end else if (rnd < SAT_MIN) begin
      out_next = SAT_MIN;
    end else begin
      out_next = rnd;
    end
  end
`else
  always_comb begin
    out_next = sum_full;
  end
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = FILL;
      FILL:    if (in_fire && (cnt_q == CNT_W'(PRE_TAPS - 1))) state_d = RUN;
      RUN:     if (last_launch) state_d = DRAIN;
      DRAIN:   if (out_fire && out_last_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      frac_q      <= '0;
      cnt_q       <= '0;
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      for (int k = 0; k < NUM_TAPS; k++) win_q[k] <= '0;
      for (int j = 0; j < NUM_PAIRS; j++) pair_q[j] <= '0;
    end else begin
      state_q <= state_d;
      if ((state_q == IDLE) && start) begin
        frac_q <= frac;
        cnt_q  <= '0;
      end else if (in_fire) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (in_fire) begin
        for (int k = 0; k < NUM_TAPS; k++) win_q[k] <= taps[k];
      end
      // Whole pipeline freezes while the output register is held.
      if (!stalled) begin
        s1_valid_q <= launch;
        s1_last_q  <= last_launch;
        if (launch) begin
          for (int j = 0; j < NUM_PAIRS; j++) pair_q[j] <= pair_d[j];
        end
        out_valid_q <= s1_valid_q;
        out_last_q  <= s1_valid_q & s1_last_q;
        if (s1_valid_q) out_data_q <= out_next;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_data  = out_data_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_affine_row_interp.sv
// Directed bench for affine_row_interp: table of row vectors (phase, input
// ramp, hand-derived raw output ramp) plus reset and protocol sequences.
module tb_affine_row_interp;

  localparam int ROW_LEN = 16;
  localparam int N_IN    = ROW_LEN + 5;

  logic               clk = 1'b0;
  logic               rst_n, start, in_valid, in_ready;
  logic               out_valid, out_ready, out_last, busy;
  logic [3:0]         frac;
  logic signed [7:0]  in_data;
  logic signed [15:0] out_data;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int frac;
    int base;      // input i = base + step*i
    int step;
    int exp_base;  // raw output n = exp_base + exp_step*n
    int exp_step;
    bit bp;        // out_ready 1,0,0,1 pattern, random in_valid
    bit hold_start;
  } vec_t;

  vec_t vecs [8];

  always #5 clk = ~clk;

  affine_row_interp #(
    .IN_SIZE (8),
    .OUT_SIZE(16),
    .ROW_LEN (ROW_LEN),
    .CNT_W   (6)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .frac     (frac),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_last (out_last),
    .busy     (busy)
  );

  function automatic int exp_val(input int raw);
    int r;
`ifdef AFFINE_ROUND_EN
    r = (raw + 32) >>> 6;
    if (r > 127) r = 127;
    if (r < -128) r = -128;
`else
    r = raw;
`endif
    return r;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run_row(input int idx, input vec_t v);
    int   sent, got, cyc, hs6, first, prev_data;
    bit   stall_prev;
    logic prev_last;
    start     = 1'b1;
    frac      = 4'(v.frac);
    in_valid  = 1'b1;
    in_data   = 8'sd99;
    out_ready = 1'b1;
    #1;
    check($sformatf("row%0d in_ready_idle", idx), int'(in_ready), 0);
    sent = 0; got = 0; cyc = 0; hs6 = -1; first = -1;
    stall_prev = 1'b0; prev_data = 0; prev_last = 1'b0;
    while (got < ROW_LEN && cyc < 2000) begin
      @(negedge clk);
      start     = v.hold_start && (sent >= 6) && (got < 10);
      out_ready = v.bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      if (sent < N_IN) begin
        in_valid = v.bp ? 1'($urandom_range(0, 1)) : 1'b1;
        in_data  = 8'(v.base + v.step * sent);
      end else begin
        in_valid = 1'b0;
        in_data  = 8'sd0;
      end
      #1;
      if (cyc == 0) check($sformatf("row%0d busy_after_start", idx), int'(busy), 1);
      if (stall_prev) begin
        check($sformatf("row%0d hold_valid", idx), int'(out_valid), 1);
        check($sformatf("row%0d hold_data", idx), int'(out_data), prev_data);
        check($sformatf("row%0d hold_last", idx), int'(out_last), int'(prev_last));
      end
      if (out_valid && first < 0) first = cyc;
      if (out_valid && out_ready) begin
        check($sformatf("row%0d data[%0d]", idx, got), int'(out_data),
              exp_val(v.exp_base + v.exp_step * got));
        check($sformatf("row%0d last[%0d]", idx, got), int'(out_last),
              int'(got == ROW_LEN - 1));
        got++;
      end
      stall_prev = out_valid && !out_ready;
      prev_data  = int'(out_data);
      prev_last  = out_last;
      if (in_valid && in_ready) begin
        sent++;
        if (sent == 6) hs6 = cyc;
      end
      cyc++;
    end
    check($sformatf("row%0d output_count", idx), got, ROW_LEN);
    check($sformatf("row%0d first_latency", idx), first - hs6, 2);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    start     = 1'b0;
    @(negedge clk);
    #1;
    check($sformatf("row%0d busy_after_last", idx), int'(busy), 0);
    check($sformatf("row%0d valid_after_last", idx), int'(out_valid), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // frac, base, step, exp_base, exp_step, bp, hold_start
    vecs[0] = '{7,   10, 0,   640,  0, 1'b0, 1'b0};  // DC row
    vecs[1] = '{0,    0, 1,   128, 64, 1'b0, 1'b0};  // passthrough of tap 2
    vecs[2] = '{5, -128, 0, -8192,  0, 1'b0, 1'b0};  // negative full scale
    vecs[3] = '{5,  127, 0,  8128,  0, 1'b0, 1'b0};  // positive full scale
    vecs[4] = '{3,    0, 1,   140, 64, 1'b0, 1'b0};  // ramp, sum k*c = 140
    vecs[5] = '{12,   0, 1,   178, 64, 1'b0, 1'b0};  // back-to-back, sum k*c = 178
    vecs[6] = '{3,    0, 1,   140, 64, 1'b1, 1'b0};  // same row under backpressure
    vecs[7] = '{8,  -10, 1,  -480, 64, 1'b0, 1'b1};  // start held during RUN

    rst_n = 1'b0; start = 1'b0; frac = 4'd0;
    in_valid = 1'b0; in_data = 8'sd0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("reset in_ready", int'(in_ready), 0);
    check("reset out_valid", int'(out_valid), 0);
    check("reset out_last", int'(out_last), 0);
    check("reset busy", int'(busy), 0);
    check("reset out_data", int'(out_data), 0);
    rst_n = 1'b1;

    // Reset in the middle of RUN abandons the row.
    @(negedge clk);
    start = 1'b1; frac = 4'd7;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; in_data = 8'sd10;
    repeat (9) @(negedge clk);
    #1;
    check("midrow out_valid", int'(out_valid), 1);
    check("midrow out_data", int'(out_data), exp_val(640));
    rst_n = 1'b0; in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("midreset in_ready", int'(in_ready), 0);
    check("midreset out_valid", int'(out_valid), 0);
    check("midreset out_last", int'(out_last), 0);
    check("midreset busy", int'(busy), 0);
    check("midreset out_data", int'(out_data), 0);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check("postreset busy", int'(busy), 0);
    check("postreset out_valid", int'(out_valid), 0);

    for (int i = 0; i < 8; i++) begin
      run_row(i, vecs[i]);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
